arbitro_escritura_registros: RTL and testbench

//  Arbitrates two writers for the single write port of the 32x32 register file
//  (banco_registros): req0 = ALU writeback, req1 = load/multicycle unit.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/arbitro_escritura_registros.sv | 142 ++++++++++++++
 tb/tb_arbitro_escritura_registros.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types for the register file, its write arbiter and the hazard logic.
//   REG_ADDR_W / REG_DATA_W : register index and word widths (32 x 32 file)
//   reg_addr_t / reg_word_t : convenience typedefs for index and word
//   arb_state_t             : write-arbiter ownership state
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_word_t;

  // ARB : free arbitration between both writers
  // OWN0: writer 0 holds the port for a locked burst
  // OWN1: writer 1 holds the port for a locked burst
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arbitro_escritura_registros.sv
// arbitro_escritura_registros
//   Arbitrates the ALU writeback (req0) and the load/multicycle unit (req1)
//   onto the single write port of the register file. Round-robin between the
//   two writers, with an optional burst lock that lets one writer keep the
//   port for up to LOCK_MAX consecutive grants. One registered stage drives
//   the register file write port.
// Ports
//   clk                      rising-edge clock
//   rsta                     asynchronous active-low reset
//   reqN_valid/reg/data/lock writer N request (held stable until ready)
//   reqN_ready               combinational grant, write accepted this cycle
//   RegWrite                 register file write enable (registered)
//   write_reg / write_data   register file write index / data (registered)
//   grant_id                 writer that owns the current output beat
module arbitro_escritura_registros
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rsta,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_lock,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_id
);

  localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  arb_state_t        state_reg, state_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  burst_len;

  logic              gnt0, gnt1, gnt_any, gnt_sel, gnt_lock, own_hold;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              regwrite_reg, regwrite_next;
  logic [ADDR_W-1:0] wr_idx_reg, wr_idx_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              grant_id_reg, grant_id_next;

  // Grant selection. An owner whose valid has dropped gives up the port in
  // the same cycle, so the fall-through branches serve the other writer.
  // Readies are forced low while reset is asserted.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    own_hold = 1'b0;
    if (rsta) begin
      if (state_reg == OWN0 && req0_valid) begin
        gnt0     = 1'b1;
        own_hold = 1'b1;
      end else if (state_reg == OWN1 && req1_valid) begin
        gnt1     = 1'b1;
        own_hold = 1'b1;
      end else if (req0_valid && req1_valid) begin
        // last_reg names the previous winner; the other one goes now
        gnt0 = last_reg;
        gnt1 = !last_reg;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next-state: ownership, burst length and round-robin pointer.
  // burst_len counts the grants of the current locked run including this one;
  // once it reaches LOCK_MAX the port is released back to arbitration.
  always_comb begin
    gnt_any    = gnt0 | gnt1;
    gnt_sel    = gnt1;
    gnt_lock   = gnt1 ? req1_lock : req0_lock;
    burst_len  = own_hold ? (cnt_reg + CNT_ONE) : CNT_ONE;
    state_next = ARB;
    cnt_next   = '0;
    last_next  = last_reg;
    if (gnt_any) begin
      last_next = gnt_sel;
      if (gnt_lock && (burst_len < LOCK_MAX_C)) begin
        state_next = gnt_sel ? OWN1 : OWN0;
        cnt_next   = burst_len;
      end
    end
  end

  // Output beat for the next cycle. Writes to x0 complete the handshake but
  // leave the port idle.
  always_comb begin
    sel_reg       = gnt1 ? req1_reg  : req0_reg;
    sel_data      = gnt1 ? req1_data : req0_data;
    regwrite_next = gnt_any && (sel_reg != '0);
    wr_idx_next   = regwrite_next ? sel_reg  : '0;
    wr_data_next  = regwrite_next ? sel_data : '0;
    grant_id_next = gnt_sel;
  end

  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      state_reg    <= ARB;
      last_reg     <= 1'b1;
      cnt_reg      <= '0;
      regwrite_reg <= 1'b0;
      wr_idx_reg   <= '0;
      wr_data_reg  <= '0;
      grant_id_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      regwrite_reg <= regwrite_next;
      wr_idx_reg   <= wr_idx_next;
      wr_data_reg  <= wr_data_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign RegWrite   = regwrite_reg;
  assign write_reg  = wr_idx_reg;
  assign write_data = wr_data_reg;
  assign grant_id   = grant_id_reg;

endmodule

// File: tb/tb_arbitro_escritura_registros.sv
// tb_arbitro_escritura_registros
//   Directed bench for the register-file write arbiter. A small register file
//   model captures the write port; per-writer beat queues drive the requests.
module tb_arbitro_escritura_registros;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic        lk;
  } beat_t;

  logic        clk;
  logic        rsta;
  logic        req0_valid, req0_lock, req0_ready;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req1_valid, req1_lock, req1_ready;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        grant_id;

  int total_cnt = 0;
  int bad_cnt   = 0;

  beat_t q0[$];
  beat_t q1[$];
  int    grant_log[$];

  logic [31:0] rf [32];
  bit          wrote_x0 = 1'b0;

  bit          exp_pend = 1'b0;
  bit          exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  logic        exp_gid;

  arbitro_escritura_registros #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .LOCK_MAX(4)
  ) dut (
    .clk       (clk),
    .rsta      (rsta),
    .req0_valid(req0_valid),
    .req0_reg  (req0_reg),
    .req0_data (req0_data),
    .req0_lock (req0_lock),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_reg  (req1_reg),
    .req1_data (req1_data),
    .req1_lock (req1_lock),
    .req1_ready(req1_ready),
    .RegWrite  (RegWrite),
    .write_reg (write_reg),
    .write_data(write_data),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register file model: x0 is hardwired, writes land on the rising edge.
  always @(posedge clk) begin
    if (RegWrite) begin
      if (write_reg == 5'd0) wrote_x0 <= 1'b1;
      else rf[write_reg] <= write_data;
    end
  end

  function automatic logic [31:0] rf_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf[idx];
  endfunction

  // Output-beat monitor: a handshake seen in one cycle must appear on the
  // write port in the next one; any other cycle must show an idle port.
  always @(negedge clk) begin
    if (!rsta) begin
      exp_pend = 1'b0;
      check_val("rst_regwrite", RegWrite, 0);
      check_val("rst_write_reg", write_reg, 0);
      check_val("rst_write_data", write_data, 0);
      check_val("rst_readies", {req0_ready, req1_ready}, 0);
    end else begin
      check_val("one_ready", req0_ready & req1_ready, 0);
      if (exp_pend) begin
        check_val("beat_regwrite", RegWrite, exp_we);
        check_val("beat_write_reg", write_reg, exp_reg);
        check_val("beat_write_data", write_data, exp_data);
        if (exp_we) check_val("beat_grant_id", grant_id, exp_gid);
      end else begin
        check_val("idle_regwrite", RegWrite, 0);
        check_val("idle_write_reg", write_reg, 0);
        check_val("idle_write_data", write_data, 0);
      end
      exp_pend = 1'b0;
      if (req0_valid && req0_ready) begin
        exp_pend = 1'b1;
        exp_we   = (req0_reg != 5'd0);
        exp_reg  = exp_we ? req0_reg : 5'd0;
        exp_data = exp_we ? req0_data : 32'd0;
        exp_gid  = 1'b0;
      end else if (req1_valid && req1_ready) begin
        exp_pend = 1'b1;
        exp_we   = (req1_reg != 5'd0);
        exp_reg  = exp_we ? req1_reg : 5'd0;
        exp_data = exp_we ? req1_data : 32'd0;
        exp_gid  = 1'b1;
      end
    end
  end

  task automatic add0(input logic [4:0] r, input logic [31:0] d, input logic lk);
    beat_t b;
    b.r = r; b.d = d; b.lk = lk;
    q0.push_back(b);
  endtask

  task automatic add1(input logic [4:0] r, input logic [31:0] d, input logic lk);
    beat_t b;
    b.r = r; b.d = d; b.lk = lk;
    q1.push_back(b);
  endtask

  task automatic apply_heads();
    if (q0.size() > 0) begin
      req0_valid = 1'b1; req0_reg = q0[0].r; req0_data = q0[0].d; req0_lock = q0[0].lk;
    end else begin
      req0_valid = 1'b0; req0_reg = '0; req0_data = '0; req0_lock = 1'b0;
    end
    if (q1.size() > 0) begin
      req1_valid = 1'b1; req1_reg = q1[0].r; req1_data = q1[0].d; req1_lock = q1[0].lk;
    end else begin
      req1_valid = 1'b0; req1_reg = '0; req1_data = '0; req1_lock = 1'b0;
    end
  endtask

  // One clock: sample handshakes mid-cycle, retire beats after the edge.
  task automatic step();
    bit g0, g1;
    @(negedge clk);
    g0 = req0_valid && req0_ready;
    g1 = req1_valid && req1_ready;
    if (g0) grant_log.push_back(0);
    else if (g1) grant_log.push_back(1);
    @(posedge clk);
    #1;
    if (g0) q0.delete(0);
    if (g1) q1.delete(0);
    apply_heads();
  endtask

  task automatic run_beats(input int max_cycles);
    int n;
    n = 0;
    apply_heads();
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    check_val("drain_timeout", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
    apply_heads();
    step();
    step();
  endtask

  task automatic check_log(input string tag, input int n, input logic [15:0] seq);
    check_val({tag, "_len"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check_val($sformatf("%s[%0d]", tag, i), grant_log[i], {31'd0, seq[i]});
    grant_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both writers requesting: no ready, idle port.
    rsta = 1'b0;
    add0(5'd1, 32'h1, 1'b0);
    add1(5'd2, 32'h2, 1'b0);
    apply_heads();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_ready0", req0_ready, 0);
    check_val("reset_ready1", req1_ready, 0);
    check_val("reset_regwrite", RegWrite, 0);
    check_val("reset_grant_id", grant_id, 0);
    q0.delete();
    q1.delete();
    apply_heads();
    rsta = 1'b1;

    // 1: single writer, ready in the same cycle, write one cycle later.
    add0(5'd1, 32'hFF, 1'b0);
    apply_heads();
    #2;
    check_val("t1_ready_same_cycle", req0_ready, 1);
    run_beats(10);
    check_log("t1_grants", 1, 16'h0);
    check_val("t1_reg1", rf_rd(5'd1), 32'hFF);
    $display("t1 single write reg1 done");

    // A req1 write moves the round-robin pointer to req1.
    add1(5'd4, 32'h44, 1'b0);
    run_beats(10);
    check_log("t1b_grants", 1, 16'h1);
    check_val("t1b_reg4", rf_rd(5'd4), 32'h44);
    $display("t1b req1 write reg4 done");

    // 2: contention, alternating grants.
    add0(5'd2, 32'hAA01, 1'b0);
    add0(5'd2, 32'hAA02, 1'b0);
    add1(5'd3, 32'h5501, 1'b0);
    add1(5'd3, 32'h5502, 1'b0);
    run_beats(20);
    check_log("t2_grants", 4, 16'hA);
    check_val("t2_reg2", rf_rd(5'd2), 32'hAA02);
    check_val("t2_reg3", rf_rd(5'd3), 32'h5502);
    $display("t2 round robin done");

    // 5: both writers target reg5; req0 first, req1's value persists.
    add0(5'd5, 32'h11, 1'b0);
    add1(5'd5, 32'h22, 1'b0);
    run_beats(10);
    check_log("t5_grants", 2, 16'h2);
    check_val("t5_reg5", rf_rd(5'd5), 32'h22);
    $display("t5 same rd done");

    // 3: write to x0 completes but never reaches the port.
    add0(5'd0, 32'h1234, 1'b0);
    run_beats(10);
    check_log("t3_grants", 1, 16'h0);
    check_val("t3_reg0", rf_rd(5'd0), 32'h0);
    check_val("t3_no_x0_write", wrote_x0, 0);
    $display("t3 x0 write done");

    // 4: locked burst of req1 forced to release after LOCK_MAX grants.
    for (int i = 0; i < 6; i++)
      add1(5'd6, 32'h601 + i, (i < 5));
    add0(5'd7, 32'h701, 1'b0);
    add0(5'd7, 32'h702, 1'b0);
    run_beats(30);
    check_log("t4_grants", 8, 16'h6F);
    check_val("t4_reg6", rf_rd(5'd6), 32'h606);
    check_val("t4_reg7", rf_rd(5'd7), 32'h702);
    $display("t4 lock burst done");

    // 4b: owner drops valid, the other writer is served in that cycle.
    add1(5'd8, 32'h801, 1'b1);
    add0(5'd11, 32'hB01, 1'b0);
    run_beats(10);
    check_log("t4b_grants", 2, 16'h1);
    check_val("t4b_reg8", rf_rd(5'd8), 32'h801);
    check_val("t4b_reg11", rf_rd(5'd11), 32'hB01);
    $display("t4b owner release done");

    // 6: reset in the middle of a req1 burst discards the in-flight beat.
    add1(5'd9, 32'h901, 1'b1);
    add1(5'd9, 32'h902, 1'b1);
    add1(5'd9, 32'h903, 1'b1);
    add1(5'd9, 32'h904, 1'b0);
    add0(5'd10, 32'hA01, 1'b0);
    apply_heads();
    step();
    step();
    check_log("t6_pre_grants", 2, 16'h3);
    check_val("t6_inflight_we", RegWrite, 1);
    check_val("t6_inflight_data", write_data, 32'h902);
    #4;
    rsta = 1'b0;
    #1;
    check_val("t6_rst_regwrite", RegWrite, 0);
    check_val("t6_rst_write_reg", write_reg, 0);
    check_val("t6_rst_write_data", write_data, 0);
    check_val("t6_rst_grant_id", grant_id, 0);
    check_val("t6_rst_readies", {req0_ready, req1_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    check_val("t6_reg9_no_write", rf_rd(5'd9), 32'h901);
    rsta = 1'b1;
    grant_log.delete();
    run_beats(20);
    check_log("t6_post_grants", 3, 16'h6);
    check_val("t6_reg9", rf_rd(5'd9), 32'h904);
    check_val("t6_reg10", rf_rd(5'd10), 32'hA01);
    $display("t6 reset mid burst done");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
